// File: rtl/arith_pkg.sv
// Shared types for the serial arithmetic blocks: control FSM states.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-wide adder slice; also exposes the carry into its MSB
// so the caller can form the two's-complement overflow flag.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] w_full;

    assign w_full = (DIGIT+1)'(a) + (DIGIT+1)'(b) + (DIGIT+1)'(cin);
    assign sum    = w_full[DIGIT-1:0];
    assign cout   = w_full[DIGIT];
    // Carry into the top bit falls out of sum = a ^ b ^ c at that position.
    assign c_msb  = w_full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit slice per
// clock, LSB first, with valid/ready handshakes on both sides.
module digit_serial_addsub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NUM_DIGITS = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS + 1);

    generate
        if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_addsub: need WIDTH >= DIGIT >= 1 and WIDTH %% DIGIT == 0");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_cout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcout;
    logic               w_dc_msb;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (r_a[DIGIT-1:0]),
        .b     (r_b[DIGIT-1:0]),
        .cin   (r_carry),
        .sum   (w_dsum),
        .cout  (w_dcout),
        .c_msb (w_dc_msb)
    );

    // Subtraction is folded in at accept time: B and the carry are stored inverted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub ? ~cin : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= WIDTH'({w_dsum, r_sum} >> DIGIT);
                    r_carry <= w_dcout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        r_cout      <= w_dcout;
                        r_ovf       <= w_dcout ^ w_dc_msb;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub at WIDTH=16, DIGIT=4.
module tb_digit_serial_addsub;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned LAT   = WIDTH / DIGIT;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks;
    int errors;

    digit_serial_addsub #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for its result; optionally scramble inputs during RUN.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic isub, input bit scramble, input bit release_out,
                          output logic [15:0] rsum, output logic rcout, output logic rovf,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'($urandom);
            end
            if (out_valid) begin
                lat = k - 1;
                break;
            end
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
        rsum = sum; rcout = cout; rovf = ovf;
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    vec_t        vecs[10];
    logic [15:0] g_sum;
    logic        g_cout;
    logic        g_ovf;
    int          g_lat;
    int          seen;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, 1'b1,
                   g_sum, g_cout, g_ovf, g_lat);
            chk($sformatf("v%0d_sum", i), 32'(g_sum), 32'(vecs[i].exp_sum));
            chk($sformatf("v%0d_cout", i), 32'(g_cout), 32'(vecs[i].exp_cout));
            chk($sformatf("v%0d_ovf", i), 32'(g_ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_latency", i), 32'(g_lat), 32'(LAT));
            chk($sformatf("v%0d_idle_after", i), 32'({in_ready, out_valid}), 32'b10);
        end

        // Backpressure: result held, new operands ignored while DONE.
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, g_sum, g_cout, g_ovf, g_lat);
        chk("bp_sum_first", 32'(g_sum), 32'h3333);
        a = 16'h0005; b = 16'h0003; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_sum", c), 32'(sum), 32'h3333);
            chk($sformatf("bp%0d_flags", c), 32'({cout, ovf}), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid || !in_ready) seen++;
        end
        chk("bp_no_phantom_accept", 32'(seen), 32'd0);

        // Reset asserted in the second RUN cycle abandons the operation.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        chk("rstrun_out_valid_during", 32'(out_valid), 32'd0);
        chk("rstrun_sum_during", 32'(sum), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstrun_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rstrun_no_result", 32'(seen), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, g_sum, g_cout, g_ovf, g_lat);
        chk("rstrun_next_sum", 32'(g_sum), 32'h0002);
        chk("rstrun_next_flags", 32'({g_cout, g_ovf}), 32'd0);
        chk("rstrun_next_latency", 32'(g_lat), 32'(LAT));

        // Inputs churn during RUN; result must reflect the accepted operands.
        run_op(16'h4321, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, g_sum, g_cout, g_ovf, g_lat);
        chk("scr_sum", 32'(g_sum), 32'h30ED);
        chk("scr_cout", 32'(g_cout), 32'd1);
        chk("scr_ovf", 32'(g_ovf), 32'd0);
        chk("scr_latency", 32'(g_lat), 32'(LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per clock.
REQ-003 SHALL have parameter constraints WIDTH >= DIGIT >= 1 and WIDTH % DIGIT == 0; violation SHALL fail elaboration.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid  in  1  operands valid.
REQ-007 SHALL have port in_ready  out  1  block can accept operands.
REQ-008 SHALL have port a  in  WIDTH  operand A.
REQ-009 SHALL have port b  in  WIDTH  operand B.
REQ-010 SHALL have port cin  in  1  carry-in (add) / borrow-in (sub).
REQ-011 SHALL have port sub  in  1  mode: 0 = add, 1 = subtract.
REQ-012 SHALL have port out_valid  out  1  result valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result.
REQ-014 SHALL have port sum  out  WIDTH  result.
REQ-015 SHALL have port cout  out  1  final carry out.
REQ-016 SHALL have port ovf  out  1  two's-complement signed overflow.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL accept operands when in_valid && in_ready; in_ready SHALL be high only in IDLE.
REQ-019 SHALL, on acceptance, register a, b, sub, cin, and clear the digit index; IDLE -> RUN.
REQ-020 SHALL define add as a + b + cin; sub as a + ~b + ~cin, i.e. a - b - cin, mod 2^WIDTH.
REQ-021 SHALL, in RUN, process one DIGIT-bit slice per cycle, LSB slice first; carry SHALL be registered between slices.
REQ-022 SHALL remain in RUN for exactly NUM_DIGITS = WIDTH/DIGIT cycles; out_valid SHALL rise NUM_DIGITS cycles after the accept edge.
REQ-023 SHALL set cout = carry out of the MSB slice (sub: 1 = no borrow); ovf = carry into MSB XOR carry out of MSB.
REQ-024 SHALL, in DONE, hold out_valid high with sum/cout/ovf stable until out_ready is sampled high.
REQ-025 SHALL, on out_valid && out_ready, go DONE -> IDLE; in_ready SHALL rise the following cycle (no same-cycle accept).
REQ-026 SHALL ignore in_valid, a, b, cin, and sub outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-027 SHALL, for DIGIT == WIDTH, complete in one RUN cycle.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force state = IDLE, in_ready = 1 after release, out_valid = 0, sum = 0, cout = 0, ovf = 0, carry and index = 0.
REQ-029 SHALL abandon any in-flight operation on reset assertion mid-RUN or in DONE; no result SHALL be presented afterward.

Structure
REQ-030 SHALL place the state typedef (IDLE/RUN/DONE) in a shared package, arith_pkg.
REQ-031 SHALL instantiate one sub-module, digit_adder: a combinational DIGIT-wide ripple adder with ports a, b, cin, sum, cout, and carry into its MSB.
REQ-032 SHALL keep datapath storage to operand shift registers, a result register, a carry flop, and an index counter of clog2(NUM_DIGITS+1) bits.

Verification (WIDTH=16, DIGIT=4)
REQ-033 SHALL cover add 0x1234 + 0x0FFF, cin=0 -> sum 0x2233, cout 0, ovf 0; out_valid exactly 4 cycles after accept.
REQ-034 SHALL cover add 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0; add 0x7FFF + 0x0001 -> sum 0x8000, cout 0, ovf 1.
REQ-035 SHALL cover sub 0x0005 - 0x0007, cin=0 -> sum 0xFFFE, cout 0, ovf 0; sub 0x8000 - 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
REQ-036 SHALL cover backpressure: out_ready held low 3 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; release -> IDLE next cycle.
REQ-037 SHALL cover rst_n pulsed low in cycle 2 of RUN -> out_valid 0 and in_ready 1 after release; next operation 0x0001 + 0x0001 -> 0x0002.
REQ-038 SHALL cover operands changed during RUN -> result matches the values captured at accept.
